// File: rtl/sdg_step_ctrl_pkg.sv
// Shared types and constants for the self-decimated generator step controller.
package sdg_step_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_STEP = 2'd1,
    ST_HOLD = 2'd2
  } sdg_state_e;

  localparam logic [31:0] SDG_TAPS_DEFAULT = 32'h8020_0003;
  localparam logic [31:0] SDG_SEED_DEFAULT = 32'h0000_0001;

  // A configured step count of zero still advances the LFSR once.
  function automatic logic [31:0] nz_count(input logic [31:0] c);
    return (c == 32'd0) ? 32'd1 : c;
  endfunction

endpackage

// File: rtl/sdg_step_ctrl_if.sv
// Seed/config and keystream handshake bundle for sdg_step_ctrl.
// Optional lockup flag present only when SDG_LOCKUP_DET_EN is defined.
interface sdg_step_ctrl_if #(
  parameter int WIDTH = 32,
  parameter int CW    = 8
);

  logic             seed_load;
  logic [WIDTH-1:0] seed;
  logic             en;
  logic [CW-1:0]    cfg_d0;
  logic [CW-1:0]    cfg_d1;
  logic             out_bit;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  logic [WIDTH-1:0] lfsr_state;
`ifdef SDG_LOCKUP_DET_EN
  logic             lockup;

  modport master (
    output seed_load, seed, en, cfg_d0, cfg_d1, out_ready,
    input  out_bit, out_valid, busy, lfsr_state, lockup
  );

  modport slave (
    input  seed_load, seed, en, cfg_d0, cfg_d1, out_ready,
    output out_bit, out_valid, busy, lfsr_state, lockup
  );
`else
  modport master (
    output seed_load, seed, en, cfg_d0, cfg_d1, out_ready,
    input  out_bit, out_valid, busy, lfsr_state
  );

  modport slave (
    input  seed_load, seed, en, cfg_d0, cfg_d1, out_ready,
    output out_bit, out_valid, busy, lfsr_state
  );
`endif

endinterface

// File: rtl/sdg_step_ctrl_lfsr.sv
// Fibonacci LFSR register with a step enable; a load overrides the step.
module sdg_step_ctrl_lfsr #(
  parameter int               WIDTH   = 32,
  parameter logic [WIDTH-1:0] TAPS    = WIDTH'(32'h8020_0003),
  parameter logic [WIDTH-1:0] RST_VAL = WIDTH'(32'h0000_0001)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             step,
  output logic [WIDTH-1:0] state
);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RST_VAL;
    end else if (load) begin
      state <= load_val;
    end else if (step) begin
      state <= {^(state & TAPS), state[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/sdg_step_ctrl.sv
// SDG sequencer: steps the LFSR D0/D1 times per group, then offers one bit on valid/ready.
// Optional SDG_LOCKUP_DET_EN adds all-zero LFSR recovery and a sticky lockup flag.
module sdg_step_ctrl
  import sdg_step_ctrl_pkg::*;
#(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] TAPS         = WIDTH'(SDG_TAPS_DEFAULT),
  parameter logic [WIDTH-1:0] SEED_DEFAULT = WIDTH'(SDG_SEED_DEFAULT),
  parameter int               CW           = 8
) (
  input logic           clk,
  input logic           rst,
  sdg_step_ctrl_if.slave bus
);

  sdg_state_e       state;
  sdg_state_e       next_state;
  logic [WIDTH-1:0] lfsr;
  logic [WIDTH-1:0] seed_sub;
  logic [WIDTH-1:0] load_val;
  logic             load;
  logic             step;
  logic             busy;
  logic             start_grp;
  logic             lock_hit;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    start_cnt;
  logic             out_bit_q;
  logic             out_valid_q;

  assign seed_sub  = (bus.seed == '0) ? SEED_DEFAULT : bus.seed;
  // cnt holds the number of shifts still owed after the current one.
  assign start_cnt = CW'(nz_count(32'(lfsr[0] ? bus.cfg_d1 : bus.cfg_d0)) - 32'd1);

`ifdef SDG_LOCKUP_DET_EN
  logic          lockup_q;
  logic [CW-1:0] restart_cnt;

  assign lock_hit    = (state == ST_STEP) && (lfsr == '0);
  // After recovery the LFSR holds SEED_DEFAULT, so its bit 0 picks the new length.
  assign restart_cnt = CW'(nz_count(32'(SEED_DEFAULT[0] ? bus.cfg_d1 : bus.cfg_d0)) - 32'd1);

  always_ff @(posedge clk) begin
    if (rst || bus.seed_load) begin
      lockup_q <= 1'b0;
    end else if (lock_hit) begin
      lockup_q <= 1'b1;
    end
  end

  assign bus.lockup = lockup_q;
`else
  assign lock_hit = 1'b0;
`endif

  sdg_step_ctrl_lfsr #(
    .WIDTH   (WIDTH),
    .TAPS    (TAPS),
    .RST_VAL (SEED_DEFAULT)
  ) u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (load_val),
    .step     (step),
    .state    (lfsr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    if (bus.seed_load) begin
      next_state = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (bus.en) next_state = ST_STEP;
        ST_STEP: if (!lock_hit && cnt == '0) next_state = ST_HOLD;
        ST_HOLD: if (bus.out_ready) next_state = bus.en ? ST_STEP : ST_IDLE;
        default: next_state = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    load      = bus.seed_load || lock_hit;
    load_val  = bus.seed_load ? seed_sub : SEED_DEFAULT;
    step      = (state == ST_STEP);
    busy      = (state == ST_STEP) || (state == ST_HOLD);
    start_grp = 1'b0;
    if (!bus.seed_load && bus.en) begin
      start_grp = (state == ST_IDLE) || (state == ST_HOLD && bus.out_ready);
    end
  end

  // Counter and output register; out_bit captures the post-shift bit 0, i.e. lfsr[1].
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      out_bit_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (bus.seed_load) begin
      out_valid_q <= 1'b0;
    end else begin
      if (start_grp) begin
        cnt <= start_cnt;
      end
      if (state == ST_HOLD && bus.out_ready && out_valid_q) begin
        out_valid_q <= 1'b0;
      end
      if (state == ST_STEP) begin
`ifdef SDG_LOCKUP_DET_EN
        if (lock_hit) begin
          cnt <= restart_cnt;
        end else
`endif
        if (cnt == '0) begin
          out_bit_q   <= lfsr[1];
          out_valid_q <= 1'b1;
        end else begin
          cnt <= cnt - 1'b1;
        end
      end
    end
  end

  assign bus.out_bit    = out_bit_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.busy       = busy;
  assign bus.lfsr_state = lfsr;

endmodule
